// File: rtl/fpu_issue_ctrl_if.sv
// Issue / writeback bundle between an FP decode stage and fpu_issue_ctrl.
// The master drives the decoded op and flush. The slave (the controller)
// answers with stall/fire and the writeback strobe.
interface fpu_issue_ctrl_if;
  // decoded op presented for issue
  logic       issue_valid;
  logic [1:0] issue_lat;
  logic [4:0] issue_rd;
  logic       issue_regwrite;
  logic [4:0] rs1i;
  logic [4:0] rs2i;
  logic [4:0] rs3i;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rs3;
  logic       flush;
  // controller responses
  logic       stall;
  logic       issue_fire;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_regwrite;
  logic       div_busy;
  logic [2:0] occupancy;

  modport master (
    output issue_valid, issue_lat, issue_rd, issue_regwrite,
    output rs1i, rs2i, rs3i, use_rs1, use_rs2, use_rs3, flush,
    input  stall, issue_fire, wb_valid, wb_rd, wb_regwrite, div_busy, occupancy
  );

  modport slave (
    input  issue_valid, issue_lat, issue_rd, issue_regwrite,
    input  rs1i, rs2i, rs3i, use_rs1, use_rs2, use_rs3, flush,
    output stall, issue_fire, wb_valid, wb_rd, wb_regwrite, div_busy, occupancy
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: tracks in-flight FP ops in a small entry table.
// It detects RAW, WAW, writeback-port, divider and table-full hazards.
// It reports one writeback per cycle.
// Writeback, div_busy and occupancy come from flops loaded with next-state
// values, so they appear in the cycle the entry table reflects them.
module fpu_issue_ctrl #(
  parameter int NENT    = 6,
  parameter int DIV_LAT = 16
) (
  input logic          clk,
  input logic          rstn,
  fpu_issue_ctrl_if.slave bus
);

  localparam logic [4:0] DIV_LAT_C = 5'(DIV_LAT);

  // latency in cycles of each latency class
  function automatic logic [4:0] lat_of(input logic [1:0] cls);
    logic [4:0] lat;
    case (cls)
      2'd0:    lat = 5'd1;
      2'd1:    lat = 5'd3;
      2'd2:    lat = 5'd4;
      default: lat = DIV_LAT_C;
    endcase
    return lat;
  endfunction

  // entry table
  logic [NENT-1:0]      valid_q, valid_d;
  logic [NENT-1:0][4:0] rd_q, rd_d;
  logic [NENT-1:0]      regwrite_q, regwrite_d;
  logic [NENT-1:0][4:0] rem_q, rem_d;
  logic [NENT-1:0]      is_div_q, is_div_d;

  // registered outputs
  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic       wb_regwrite_q, wb_regwrite_d;
  logic       div_busy_q, div_busy_d;
  logic [2:0] occupancy_q, occupancy_d;

  // hazard / control terms
  logic [4:0] new_lat_s;
  logic [5:0] new_lat_p1_s;
  logic       raw_hit_s;
  logic       port_hit_s;
  logic       waw_hit_s;
  logic       div_hit_s;
  logic       full_s;
  logic       stall_s;
  logic       fire_s;
  logic       alloc_done_s;
  logic [3:0] occ_cnt_s;

  // Hazard detection against the current table.
  // An entry at rem==1 is forwarded, so it does not count for RAW.
  // The port check compares in 6 bits so DIV_LAT=31 cannot wrap.
  always_comb begin
    raw_hit_s    = 1'b0;
    port_hit_s   = 1'b0;
    waw_hit_s    = 1'b0;
    new_lat_s    = lat_of(bus.issue_lat);
    new_lat_p1_s = {1'b0, new_lat_s} + 6'd1;
    for (int i = 0; i < NENT; i++) begin
      raw_hit_s  = raw_hit_s
                 | (valid_q[i] & regwrite_q[i] & (rem_q[i] > 5'd1)
                    & ((bus.use_rs1 & (bus.rs1i == rd_q[i]))
                     | (bus.use_rs2 & (bus.rs2i == rd_q[i]))
                     | (bus.use_rs3 & (bus.rs3i == rd_q[i]))));
      port_hit_s = port_hit_s | (valid_q[i] & ({1'b0, rem_q[i]} == new_lat_p1_s));
      waw_hit_s  = waw_hit_s
                 | (valid_q[i] & regwrite_q[i] & bus.issue_regwrite & (rd_q[i] == bus.issue_rd));
    end
    div_hit_s = (bus.issue_lat == 2'd3) & div_busy_q;
    full_s    = &valid_q;
    stall_s   = bus.issue_valid & (raw_hit_s | port_hit_s | waw_hit_s | div_hit_s | full_s);
    fire_s    = rstn & bus.issue_valid & ~stall_s & ~bus.flush;
  end

  // Table next state: age entries, retire rem==1, allocate, apply flush.
  // The values for the registered outputs come from the next table state.
  always_comb begin
    valid_d      = valid_q;
    rd_d         = rd_q;
    regwrite_d   = regwrite_q;
    rem_d        = rem_q;
    is_div_d     = is_div_q;
    alloc_done_s = 1'b0;

    for (int i = 0; i < NENT; i++) begin
      if (valid_q[i] && (rem_q[i] > 5'd1)) begin
        rem_d[i] = rem_q[i] - 5'd1;
      end else begin
        valid_d[i] = 1'b0;
      end
    end

    // A retiring entry is still occupied this cycle, so only ~valid_q slots are free.
    for (int i = 0; i < NENT; i++) begin
      if (fire_s && !alloc_done_s && !valid_q[i]) begin
        valid_d[i]    = 1'b1;
        rd_d[i]       = bus.issue_rd;
        regwrite_d[i] = bus.issue_regwrite;
        rem_d[i]      = new_lat_s;
        is_div_d[i]   = (bus.issue_lat == 2'd3);
        alloc_done_s  = 1'b1;
      end else begin
        alloc_done_s  = alloc_done_s;
      end
    end

    if (bus.flush) begin
      valid_d = '0;
    end else begin
      valid_d = valid_d;
    end

    wb_valid_d    = 1'b0;
    wb_rd_d       = 5'd0;
    wb_regwrite_d = 1'b0;
    div_busy_d    = 1'b0;
    occ_cnt_s     = 4'd0;
    for (int i = 0; i < NENT; i++) begin
      if (valid_d[i] && (rem_d[i] == 5'd1)) begin
        wb_valid_d    = 1'b1;
        wb_rd_d       = rd_d[i];
        wb_regwrite_d = regwrite_d[i];
      end else begin
        wb_valid_d    = wb_valid_d;
      end
      div_busy_d = div_busy_d | (valid_d[i] & is_div_d[i]);
      occ_cnt_s  = occ_cnt_s + 4'(valid_d[i]);
    end
    occupancy_d = occ_cnt_s[2:0];
  end

  // State and output registers, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      rd_q          <= '0;
      regwrite_q    <= '0;
      rem_q         <= '0;
      is_div_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      div_busy_q    <= 1'b0;
      occupancy_q   <= 3'd0;
    end else begin
      valid_q       <= valid_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      rem_q         <= rem_d;
      is_div_q      <= is_div_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      div_busy_q    <= div_busy_d;
      occupancy_q   <= occupancy_d;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.issue_fire  = fire_s;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.div_busy    = div_busy_q;
  assign bus.occupancy   = occupancy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl.
// Each accepted op pushes its expected writeback (cycle, rd, regwrite) to a
// scoreboard. A negedge monitor pops and compares writebacks, occupancy and
// div_busy. A second copy with NENT=4 shares the stimulus so the table-full
// stall can be reached.
module tb_fpu_issue_ctrl;
  localparam int TB_NENT = 6;
  localparam int TB_DIV  = 16;

  typedef struct {
    int         fire;
    int         due;
    logic [4:0] rd;
    logic       rw;
    logic       is_div;
  } sb_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb[$];

  fpu_issue_ctrl_if ifc ();
  fpu_issue_ctrl_if fi ();

  fpu_issue_ctrl #(.NENT(TB_NENT), .DIV_LAT(TB_DIV)) dut (
    .clk(clk), .rstn(rstn), .bus(ifc)
  );

  fpu_issue_ctrl #(.NENT(4), .DIV_LAT(TB_DIV)) dut_small (
    .clk(clk), .rstn(rstn), .bus(fi)
  );

  assign fi.issue_valid    = ifc.issue_valid;
  assign fi.issue_lat      = ifc.issue_lat;
  assign fi.issue_rd       = ifc.issue_rd;
  assign fi.issue_regwrite = ifc.issue_regwrite;
  assign fi.rs1i           = ifc.rs1i;
  assign fi.rs2i           = ifc.rs2i;
  assign fi.rs3i           = ifc.rs3i;
  assign fi.use_rs1        = ifc.use_rs1;
  assign fi.use_rs2        = ifc.use_rs2;
  assign fi.use_rs3        = ifc.use_rs3;
  assign fi.flush          = ifc.flush;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [1:0] cls);
    int l;
    case (cls)
      2'd0:    l = 1;
      2'd1:    l = 3;
      2'd2:    l = 4;
      default: l = TB_DIV;
    endcase
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_idle();
    ifc.issue_valid = 1'b0; ifc.issue_lat = 2'd0; ifc.issue_rd = 5'd0; ifc.issue_regwrite = 1'b0;
    ifc.rs1i = 5'd0; ifc.rs2i = 5'd0; ifc.rs3i = 5'd0;
    ifc.use_rs1 = 1'b0; ifc.use_rs2 = 1'b0; ifc.use_rs3 = 1'b0; ifc.flush = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] cls, input logic [4:0] rd, input logic rw);
    set_idle();
    ifc.issue_valid = 1'b1; ifc.issue_lat = cls; ifc.issue_rd = rd; ifc.issue_regwrite = rw;
  endtask

  // Check stall/fire at the negedge. Record an op the bench expects to be accepted.
  task automatic sample(input logic exp_stall);
    logic exp_fire;
    sb_t  e;
    @(negedge clk);
    exp_fire = ifc.issue_valid & ~exp_stall & ~ifc.flush;
    chk("stall", 32'(ifc.stall), 32'(exp_stall));
    chk("issue_fire", 32'(ifc.issue_fire), 32'(exp_fire));
    if (exp_fire) begin
      e.fire = cyc; e.due = cyc + exp_lat(ifc.issue_lat);
      e.rd = ifc.issue_rd; e.rw = ifc.issue_regwrite; e.is_div = (ifc.issue_lat == 2'd3);
      sb.push_back(e);
    end
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic exp_stall);
    sample(exp_stall);
    advance();
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) step(1'b0);
  endtask

  // Scoreboard monitor: check occupancy, div_busy and writeback each cycle.
  always @(negedge clk) begin
    int   occ;
    logic db;
    int   hit;
    if (!rstn) begin
      chk("rst_stall", 32'(ifc.stall), 32'd0);
      chk("rst_issue_fire", 32'(ifc.issue_fire), 32'd0);
      chk("rst_wb_valid", 32'(ifc.wb_valid), 32'd0);
      chk("rst_wb_rd", 32'(ifc.wb_rd), 32'd0);
      chk("rst_wb_regwrite", 32'(ifc.wb_regwrite), 32'd0);
      chk("rst_div_busy", 32'(ifc.div_busy), 32'd0);
      chk("rst_occupancy", 32'(ifc.occupancy), 32'd0);
      sb.delete();
    end else begin
      occ = 0; db = 1'b0; hit = -1;
      foreach (sb[k]) begin
        if (sb[k].fire < cyc) begin
          occ++;
          if (sb[k].is_div) db = 1'b1;
        end
        if (sb[k].due == cyc) hit = k;
      end
      chk("occupancy", 32'(ifc.occupancy), 32'(occ));
      chk("div_busy", 32'(ifc.div_busy), 32'(db));
      chk("wb_valid", 32'(ifc.wb_valid), (hit >= 0) ? 32'd1 : 32'd0);
      if (hit >= 0) begin
        chk("wb_rd", 32'(ifc.wb_rd), 32'(sb[hit].rd));
        chk("wb_regwrite", 32'(ifc.wb_regwrite), 32'(sb[hit].rw));
        sb.delete(hit);
      end
      if (ifc.flush) sb.delete();
    end
  end

  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    // an op presented during reset is neither stalled nor fired
    set_op(2'd0, 5'd1, 1'b1);
    @(negedge clk);
    chk("rst_hold_stall", 32'(ifc.stall), 32'd0);
    chk("rst_hold_fire", 32'(ifc.issue_fire), 32'd0);
    advance();

    // first cycle after release: class-1 rd=3, writeback 3 cycles later
    rstn = 1'b1;
    set_op(2'd1, 5'd3, 1'b1); step(1'b0);
    idle(4);

    // RAW on rs1: stalled while rem>1, issues on the bypass cycle
    set_op(2'd1, 5'd5, 1'b1); step(1'b0);
    set_op(2'd0, 5'd6, 1'b1); ifc.rs1i = 5'd5; ifc.use_rs1 = 1'b1;
    step(1'b1); step(1'b1); step(1'b0);
    idle(2);

    // unused rs3 never stalls; RAW through rs2
    set_op(2'd1, 5'd1, 1'b1); step(1'b0);
    set_op(2'd0, 5'd2, 1'b1); ifc.rs3i = 5'd1; step(1'b0);
    set_op(2'd2, 5'd3, 1'b1); ifc.rs2i = 5'd1; ifc.use_rs2 = 1'b1;
    step(1'b1); step(1'b0);
    idle(5);

    // writeback port conflict: class-2 then class-1
    set_op(2'd2, 5'd7, 1'b1); step(1'b0);
    set_op(2'd1, 5'd8, 1'b1); step(1'b1); step(1'b0);
    idle(4);

    // WAW on x0: no stall without regwrite, stall with it until retired
    set_op(2'd2, 5'd0, 1'b1); step(1'b0);
    set_op(2'd0, 5'd0, 1'b0); step(1'b0);
    set_op(2'd0, 5'd0, 1'b1); step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    idle(2);

    // divider: second fdiv waits until DIV_LAT+1, class-0 ops slip in
    set_op(2'd3, 5'd10, 1'b1); step(1'b0);
    set_op(2'd3, 5'd11, 1'b1); repeat (4) step(1'b1);
    set_op(2'd0, 5'd12, 1'b1); step(1'b0);
    set_op(2'd0, 5'd13, 1'b1); step(1'b0);
    set_op(2'd3, 5'd11, 1'b1); repeat (TB_DIV - 6) step(1'b1);
    step(1'b0);

    // three in flight (one at rem==1), then flush together with a valid op
    set_op(2'd1, 5'd12, 1'b1); step(1'b0);
    set_op(2'd1, 5'd13, 1'b1); step(1'b0);
    idle(1);
    set_op(2'd2, 5'd14, 1'b1); ifc.flush = 1'b1; step(1'b0);
    idle(4);

    // six independent class-1 ops back-to-back, all accepted
    for (int k = 0; k < 6; k++) begin
      set_op(2'd1, 5'(16 + k), 1'b1); step(1'b0);
    end
    idle(4);

    // fill the NENT=4 copy with class-2 ops; a 5th op stalls there only
    for (int k = 0; k < 4; k++) begin
      set_op(2'd2, 5'(22 + k), 1'b1); step(1'b0);
    end
    set_op(2'd2, 5'd26, 1'b1);
    sample(1'b0);
    chk("full_stall", 32'(fi.stall), 32'd1);
    chk("full_fire", 32'(fi.issue_fire), 32'd0);
    chk("full_occupancy", 32'(fi.occupancy), 32'd4);
    advance();
    idle(5);

    // reset mid-operation abandons the in-flight op
    set_op(2'd2, 5'd27, 1'b1); step(1'b0);
    set_idle(); rstn = 1'b0; step(1'b0);
    rstn = 1'b1;
    set_op(2'd0, 5'd27, 1'b1); step(1'b0);
    idle(6);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
